fifo_push_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of one single-clock FIFO between `NB_REQ` requesters. Each requester has a valid/ready handshake. The arbiter forwards the granted requester's beat to the FIFO push interface, tagged with the requester index, and supports bounded burst locking so short packets stay contiguous in the FIFO. It sits between the tree-engine request sources and the shared command FIFO.

---
 rtl/fifo_push_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
// Shares the write port of one single-clock FIFO between NB_REQ requesters.
// Fresh grants rotate round-robin from rr_ptr. A requester that pushes keeps
// the port for up to MAX_BURST consecutive beats so short packets stay
// contiguous in the FIFO. A locked requester that drops valid hands over the
// port in the same cycle, so there are no bubbles.
//
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   req_valid      per-requester beat valid
//   req_data       requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      one-hot (or zero) ready back to the selected requester
//   fifo_data      {grant_id, payload} written to the FIFO
//   fifo_push      FIFO write strobe
//   fifo_full      FIFO full flag; stalls the transfer without moving the lock
//   grant_id       index of the selected requester, meaningful while busy
//   busy           a requester (locked or freshly arbitrated) is selected
module fifo_push_arbiter #(
    parameter int NB_REQ     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int IDW        = $clog2(NB_REQ)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NB_REQ-1:0]            req_valid,
    input  logic [NB_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NB_REQ-1:0]            req_ready,
    output logic [IDW+DATA_WIDTH-1:0]    fifo_data,
    output logic                         fifo_push,
    input  logic                         fifo_full,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(NB_REQ - 1);
    localparam logic [CW-1:0]  BURST_END = CW'(MAX_BURST);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

    logic             owner_valid;
    logic             hold_lock;
    logic [IDW-1:0]   scan_base;
    logic             scan_hit;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   cand_idx;
    int               cand;
    int               sel_base;
    logic [IDW-1:0]   sel;
    logic             busy_raw;
    logic [CW-1:0]    cnt_next;

    // Increment modulo NB_REQ, so non-power-of-two counts wrap to 0.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Selection. When a lock is lost because the owner went idle, the fresh
    // scan starts just after the owner rather than at rr_ptr, so the
    // handover happens in the same cycle. The scan runs from the far end so
    // the lowest offset from scan_base wins without needing a loop break.
    always_comb begin
        owner_valid = req_valid[owner_q];
        hold_lock   = (state_q == LOCK) && owner_valid;
        scan_base   = (state_q == LOCK) ? wrap_inc(owner_q) : rr_ptr_q;
        scan_hit    = 1'b0;
        scan_idx    = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            cand     = (int'(scan_base) + k) % NB_REQ;
            cand_idx = IDW'(cand);
            if (req_valid[cand_idx]) begin
                scan_hit = 1'b1;
                scan_idx = cand_idx;
            end
        end
        sel      = hold_lock ? owner_q : scan_idx;
        busy_raw = hold_lock | scan_hit;
    end

    // Outputs are gated by aresetn so nothing is granted while reset is held,
    // even though req_valid may still be asserted.
    always_comb begin
        busy      = aresetn & busy_raw;
        grant_id  = busy ? sel : '0;
        fifo_push = busy & ~fifo_full;
        req_ready = '0;
        if (fifo_push) begin
            req_ready[sel] = 1'b1;
        end
        sel_base  = int'(sel) * DATA_WIDTH;
        fifo_data = {sel, req_data[sel_base +: DATA_WIDTH]};
    end

    // Burst bookkeeping. A push always wins over the idle-owner drop; a
    // stalled fresh winner is not recorded, so the scan simply repeats.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        cnt_next   = (hold_lock ? beat_cnt_q : '0) + 1'b1;
        if (fifo_push) begin
            if (cnt_next == BURST_END) begin
                state_d    = ARB;
                beat_cnt_d = '0;
                rr_ptr_d   = wrap_inc(sel);
            end else begin
                state_d    = LOCK;
                owner_d    = sel;
                beat_cnt_d = cnt_next;
            end
        end else if ((state_q == LOCK) && !owner_valid) begin
            state_d    = ARB;
            beat_cnt_d = '0;
            rr_ptr_d   = wrap_inc(owner_q);
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter
// Drives two arbiter instances from shared stimulus: a 4-requester,
// burst-of-4 instance and a 3-requester pure round-robin instance. Expected
// outputs come from a per-instance model holding the current burst owner
// (or -1), the beats taken so far and the next fresh-scan start index.
module tb_fifo_push_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        fifo_full;

    logic [3:0]  a_ready;
    logic [9:0]  a_data;
    logic        a_push;
    logic [1:0]  a_grant;
    logic        a_busy;

    logic [2:0]  b_ready;
    logic [9:0]  b_data;
    logic        b_push;
    logic [1:0]  b_grant;
    logic        b_busy;

    int n_compared   = 0;
    int n_mismatched = 0;
    int a_pushes     = 0;

    int n_req [2] = '{4, 3};
    int max_b [2] = '{4, 1};
    int m_owner [2];
    int m_count [2];
    int m_next [2];

    fifo_push_arbiter #(.NB_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_a (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (a_ready),
        .fifo_data (a_data),
        .fifo_push (a_push),
        .fifo_full (fifo_full),
        .grant_id  (a_grant),
        .busy      (a_busy)
    );

    fifo_push_arbiter #(.NB_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid[2:0]),
        .req_data  (req_data[23:0]),
        .req_ready (b_ready),
        .fifo_data (b_data),
        .fifo_push (b_push),
        .fifo_full (fifo_full),
        .grant_id  (b_grant),
        .busy      (b_busy)
    );

    // Free-running clock, period 10.
    always #5 aclk = ~aclk;

    function automatic bit vbit(input logic [3:0] v, input int i);
        return v[i[1:0]];
    endfunction

    // Who should be selected right now, and whether it continues a burst.
    function automatic void model_eval(input int inst, input logic [3:0] v,
                                       output int sel, output bit bsy, output bit cont);
        int n;
        int start;
        int idx;
        n    = n_req[inst];
        sel  = 0;
        bsy  = 1'b0;
        cont = 1'b0;
        if (m_owner[inst] >= 0 && vbit(v, m_owner[inst])) begin
            sel  = m_owner[inst];
            bsy  = 1'b1;
            cont = 1'b1;
        end else begin
            start = (m_owner[inst] >= 0) ? (m_owner[inst] + 1) % n : m_next[inst];
            for (int k = 0; k < n; k++) begin
                idx = (start + k) % n;
                if (!bsy && vbit(v, idx)) begin
                    sel = idx;
                    bsy = 1'b1;
                end
            end
        end
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_step(input int inst, input logic [3:0] v, input logic full);
        int sel;
        bit bsy;
        bit cont;
        int n;
        n = n_req[inst];
        model_eval(inst, v, sel, bsy, cont);
        if (m_owner[inst] >= 0 && !vbit(v, m_owner[inst])) begin
            m_next[inst]  = (m_owner[inst] + 1) % n;
            m_owner[inst] = -1;
            m_count[inst] = 0;
        end
        if (bsy && !full) begin
            m_count[inst] = (cont ? m_count[inst] : 0) + 1;
            if (m_count[inst] == max_b[inst]) begin
                m_owner[inst] = -1;
                m_count[inst] = 0;
                m_next[inst]  = (sel + 1) % n;
            end else begin
                m_owner[inst] = sel;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_count[i] = 0;
            m_next[i]  = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic full, input logic [31:0] data);
        req_valid = v;
        fifo_full = full;
        req_data  = data;
    endtask

    task automatic checkOutput(input string phase);
        int          sel;
        bit          bsy;
        bit          cont;
        bit          push;
        logic        o_busy;
        logic        o_push;
        logic [3:0]  o_ready;
        logic [1:0]  o_grant;
        logic [9:0]  o_data;
        string       nm;
        for (int inst = 0; inst < 2; inst++) begin
            nm      = (inst == 0) ? "a" : "b";
            o_busy  = (inst == 0) ? a_busy  : b_busy;
            o_push  = (inst == 0) ? a_push  : b_push;
            o_ready = (inst == 0) ? a_ready : {1'b0, b_ready};
            o_grant = (inst == 0) ? a_grant : b_grant;
            o_data  = (inst == 0) ? a_data  : b_data;
            if (!aresetn) begin
                check($sformatf("%s/%s_busy", phase, nm), o_busy, 0);
                check($sformatf("%s/%s_push", phase, nm), o_push, 0);
                check($sformatf("%s/%s_ready", phase, nm), o_ready, 0);
                check($sformatf("%s/%s_grant", phase, nm), o_grant, 0);
            end else begin
                model_eval(inst, req_valid, sel, bsy, cont);
                push = bsy && !fifo_full;
                check($sformatf("%s/%s_busy", phase, nm), o_busy, bsy);
                check($sformatf("%s/%s_push", phase, nm), o_push, push);
                check($sformatf("%s/%s_ready", phase, nm), o_ready, push ? (32'd1 << sel) : 32'd0);
                if (bsy) begin
                    check($sformatf("%s/%s_grant", phase, nm), o_grant, sel);
                end
                if (push) begin
                    check($sformatf("%s/%s_data", phase, nm), o_data,
                          {sel[1:0], req_data[sel*8 +: 8]});
                end
            end
        end
    endtask

    // One cycle: drive on the falling edge, check mid-low phase, then let the
    // model follow the rising edge that uses these inputs.
    task automatic cycle(input string phase, input logic [3:0] v, input logic full,
                         input logic [31:0] data);
        @(negedge aclk);
        applyStimulus(v, full, data);
        #1;
        checkOutput(phase);
        if (a_push) a_pushes++;
        model_step(0, v, full);
        model_step(1, v, full);
    endtask

    // Reset for one full cycle with requests still pending; released with
    // all valids low so the first post-reset edge does nothing.
    task automatic pulse_reset(input string phase, input logic [3:0] v);
        @(negedge aclk);
        aresetn = 1'b0;
        applyStimulus(v, 1'b0, 32'hA3A2_A1A0);
        #1;
        checkOutput(phase);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        applyStimulus(4'b0000, 1'b0, 32'hA3A2_A1A0);
    endtask

    localparam logic [31:0] PAY = 32'hA3A2_A1A0;

    initial begin
        aresetn = 1'b0;
        applyStimulus(4'hF, 1'b0, PAY);
        model_reset();
        #1;
        checkOutput("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        applyStimulus(4'b0000, 1'b0, PAY);

        // All requesters valid: bursts of four on A, strict rotation on B.
        a_pushes = 0;
        for (int i = 0; i < 16; i++) cycle("all_valid", 4'hF, 1'b0, PAY);
        check("all_valid/push_count", a_pushes, 16);

        // Two sparse requesters.
        pulse_reset("rst2", 4'hF);
        for (int i = 0; i < 8; i++) cycle("sparse", 4'b1010, 1'b0, PAY);
        for (int i = 0; i < 6; i++) cycle("sparse_b", 4'b0101, 1'b0, PAY);

        // Lock on 2, stall five cycles with 0 also waiting, then resume.
        pulse_reset("rst3", 4'hF);
        for (int i = 0; i < 2; i++) cycle("lock2", 4'b0100, 1'b0, PAY);
        for (int i = 0; i < 5; i++) cycle("stall", 4'b0101, 1'b1, PAY);
        for (int i = 0; i < 4; i++) cycle("resume", 4'b0101, 1'b0, PAY);

        // Owner 1 goes idle after one beat while 3 is waiting.
        pulse_reset("rst4", 4'hF);
        cycle("lock1", 4'b0010, 1'b0, PAY);
        for (int i = 0; i < 4; i++) cycle("handover", 4'b1000, 1'b0, PAY);
        cycle("after_handover", 4'hF, 1'b0, PAY);

        // Reset in the middle of a burst on 2, then 0 and 2 compete.
        pulse_reset("rst6", 4'hF);
        for (int i = 0; i < 2; i++) cycle("burst2", 4'b0100, 1'b0, PAY);
        pulse_reset("mid_burst_rst", 4'b0100);
        for (int i = 0; i < 3; i++) cycle("post_rst", 4'b0101, 1'b0, PAY);

        // Randomised traffic with occasional stalls and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset("rand_rst", 4'($urandom));
            end else begin
                cycle("rand", 4'($urandom), ($urandom_range(0, 3) == 0), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
